// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: redirect, instruction-memory and decode-side signals of the fetch front end
// Ports (signals): redirect_valid/redirect_target from branch unit; imem_req_* request channel;
// imem_rsp_* response channel (in order, no backpressure); if_* instruction stream to decode.
// master = fetch unit side, slave = environment side.
interface fetch_redirect_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus_4;
    modport master (
        input  redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_pc_plus_4
    );
    modport slave (
        output redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_pc_plus_4
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC generation, credit-limited instruction fetch, PC-tagged instruction buffer, redirect flush
// Ports: clk, rst (sync active-high); bus (master modport): redirect in, imem request out/response in,
// decode stream out (if_valid/if_ready/if_pc/if_instr/if_pc_plus_4).
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                   clk,
    input logic                   rst,
    fetch_redirect_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [0:0]    state_q, state_d;
    logic [31:0]   tag_mem [DEPTH];
    logic [31:0]   fifo_pc_mem [DEPTH];
    logic [31:0]   fifo_instr_mem [DEPTH];
    logic [31:0]   if_pc;
    logic          req_fire, rsp_drop, rsp_keep, if_fire;

    always_comb begin
        bus.imem_req_valid = !rst && !bus.redirect_valid &&
                             ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q} < (CW+1)'(DEPTH));
        bus.imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
        bus.if_valid       = !rst && !bus.redirect_valid && fifo_cnt_q != '0;
        if_pc              = rst ? 32'h0 : fifo_pc_mem[fifo_rd_q];
        bus.if_pc          = if_pc;
        bus.if_instr       = rst ? 32'h0 : fifo_instr_mem[fifo_rd_q];
        bus.if_pc_plus_4   = if_pc + 32'd4;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        // while draining, every arriving response belongs to a pre-redirect request
        rsp_drop           = bus.imem_rsp_valid && state_q == DRAIN;
        rsp_keep           = bus.imem_rsp_valid && state_q == RUN && !bus.redirect_valid;
        if_fire            = bus.if_valid && bus.if_ready;
        fetch_pc_d         = bus.redirect_valid ? (bus.redirect_target & ~32'h3) :
                             req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // dropped responses never had a tag in the queue after the redirect cleared it
        tag_wr_d           = tag_wr_q + AW'(req_fire);
        tag_rd_d           = bus.redirect_valid ? tag_wr_q : tag_rd_q + AW'(rsp_keep);
        fifo_wr_d          = fifo_wr_q + AW'(rsp_keep);
        fifo_rd_d          = bus.redirect_valid ? fifo_wr_q : fifo_rd_q + AW'(if_fire);
        fifo_cnt_d         = bus.redirect_valid ? '0 : fifo_cnt_q + CW'(rsp_keep) - CW'(if_fire);
        // no request is issued on a redirect, so this is also outstanding minus a same-cycle response
        outstanding_d      = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        drop_cnt_d         = bus.redirect_valid ? outstanding_d : drop_cnt_q - CW'(rsp_drop);
        state_d            = drop_cnt_d != '0 ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) tag_mem[tag_wr_q] <= fetch_pc_q;
        if (rsp_keep) begin
            fifo_pc_mem[fifo_wr_q]    <= tag_mem[tag_rd_q];
            fifo_instr_mem[fifo_wr_q] <= bus.imem_rsp_data;
        end
    end

    // the credit limit keeps the buffer from ever being full when a response lands
    assert property (@(posedge clk) disable iff (rst) !(rsp_keep && fifo_cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: scoreboard bench with a request-level memory model and an epoch-based expected-instruction queue
module tb_fetch_redirect_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {logic [31:0] addr; int due; int ep;} req_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_redirect_unit_if bus();
    fetch_redirect_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    req_t        mq[$];
    ins_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    logic [31:0] model_pc = RESET_PC;
    ins_t        mon_e;
    req_t        mod_r;
    logic        found;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        bus.imem_rsp_valid = !rst && mq.size() > 0 && mq[0].due <= cyc;
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_data(mq[0].addr) : 32'h0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
            chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
            chk("rst_if_pc", bus.if_pc, 32'd0);
            chk("rst_if_instr", bus.if_instr, 32'd0);
            chk("rst_if_pc_plus_4", bus.if_pc_plus_4, 32'd4);
        end else begin
            chk("req_valid", 32'(bus.imem_req_valid),
                32'(!bus.redirect_valid && (mq.size() + exp_q.size() < DEPTH)));
            chk("if_valid", 32'(bus.if_valid), 32'(!bus.redirect_valid && exp_q.size() > 0));
            if (bus.if_valid && bus.if_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("if_pc", bus.if_pc, mon_e.pc);
                chk("if_instr", bus.if_instr, mon_e.instr);
                chk("if_pc_plus_4", bus.if_pc_plus_4, mon_e.pc + 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            model_pc = RESET_PC;
            epoch++;
        end else begin
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, model_pc);
            if (bus.imem_rsp_valid && mq.size() > 0) begin
                mod_r = mq.pop_front();
                if (!bus.redirect_valid && mod_r.ep == epoch)
                    exp_q.push_back('{mod_r.addr, mem_data(mod_r.addr)});
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                epoch++;
                model_pc = bus.redirect_target & ~32'h3;
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{model_pc, cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
                model_pc += 32'd4;
            end
        end
    end

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.imem_req_ready  = 1'b1;
        bus.if_ready        = 1'b1;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);
        bus.if_ready = 1'b0;
        step(10);
        bus.if_ready = 1'b1;
        step(10);
        lat_lo = 3;
        lat_hi = 3;
        step(6);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h100;
        step(1);
        bus.redirect_valid = 1'b0;
        step(20);
        lat_lo = 1;
        lat_hi = 1;
        step(4);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #3;
            found = bus.imem_rsp_valid && bus.if_valid && bus.if_ready;
        end
        chk("align_rsp_and_handshake", 32'(found), 32'd1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h203;
        step(1);
        bus.redirect_valid = 1'b0;
        step(15);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h40;
        step(1);
        bus.redirect_target = 32'h80;
        step(1);
        bus.redirect_valid = 1'b0;
        step(15);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFF8;
        step(1);
        bus.redirect_valid = 1'b0;
        step(12);
        bus.if_ready = 1'b0;
        lat_lo = 3;
        lat_hi = 3;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.if_ready = 1'b1;
        lat_lo = 1;
        lat_hi = 1;
        step(10);
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            bus.if_ready        = $urandom_range(3) != 0;
            bus.imem_req_ready  = $urandom_range(3) != 0;
            bus.redirect_valid  = $urandom_range(15) == 0;
            bus.redirect_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            rst                 = $urandom_range(499) == 0;
            step(1);
        end
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        step(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
